// File: rtl/alert_cadence_ctrl.sv
// alert_cadence_ctrl: fixed-priority multi-source alert controller that drives
// the ringer and vibration motor with a timed ON/OFF cadence and auto-stops.
// Ports:
//   clk, reset_n     clock and synchronous active-low reset
//   req[NUM_SRC]     level alert requests, index 0 highest priority
//   mode[2]          00 ring, 01 vibrate, 10 silent, 11 ring+vibrate
//   dismiss          single-cycle user dismiss of the current alert
//   ringer, motor    registered driver enables
//   active           high while an alert is in its ON or OFF phase
//   active_src       index of the serviced source, held while idle
//   missed           one-cycle pulse when the alert auto-stops
module alert_cadence_ctrl #(
    parameter int NUM_SRC    = 4,
    parameter int ON_CYC     = 8,
    parameter int OFF_CYC    = 8,
    parameter int MAX_BURSTS = 3,
    localparam int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         mode,
    input  logic               dismiss,
    output logic               ringer,
    output logic               motor,
    output logic               active,
    output logic [SRC_W-1:0]   active_src,
    output logic               missed
);

    localparam int PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BU_W   = (MAX_BURSTS > 1) ? $clog2(MAX_BURSTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [BU_W-1:0]    burst_q, burst_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic               ringer_q, ringer_d;
    logic               motor_q, motor_d;
    logic               active_q, active_d;
    logic               missed_q, missed_d;

    logic [NUM_SRC-1:0] elig;
    logic [SRC_W-1:0]   low;
    logic               any_elig;

    // Lowest-index eligible source; a masked source stays ineligible until
    // its request has been seen low at least once.
    always_comb begin
        elig     = req & ~mask_q;
        any_elig = |elig;
        low      = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                low = SRC_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        burst_d  = burst_q;
        src_d    = src_q;
        mask_d   = mask_q & req;
        missed_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = ON;
                    src_d   = low;
                    phase_d = '0;
                    burst_d = '0;
                end
            end
            ON, OFF: begin
                // Order of tests encodes event priority:
                // dismiss > release > preemption > timeout.
                if (dismiss) begin
                    state_d       = IDLE;
                    phase_d       = '0;
                    burst_d       = '0;
                    mask_d[src_q] = 1'b1;
                end else if (!req[src_q]) begin
                    state_d = IDLE;
                    phase_d = '0;
                    burst_d = '0;
                end else if (any_elig && (low < src_q)) begin
                    state_d = ON;
                    src_d   = low;
                    phase_d = '0;
                    burst_d = '0;
                end else if (state_q == ON) begin
                    if (phase_q == PH_W'(ON_CYC - 1)) begin
                        state_d = OFF;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end else begin
                    if (phase_q == PH_W'(OFF_CYC - 1)) begin
                        phase_d = '0;
                        if (burst_q == BU_W'(MAX_BURSTS - 1)) begin
                            state_d       = IDLE;
                            burst_d       = '0;
                            missed_d      = 1'b1;
                            mask_d[src_q] = 1'b1;
                        end else begin
                            state_d = ON;
                            burst_d = burst_q + BU_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                burst_d = '0;
            end
        endcase

        // Drivers follow the state being entered, using this cycle's mode,
        // so every output is exactly one cycle behind its inputs.
        active_d = (state_d != IDLE);
        ringer_d = (state_d == ON) && ((mode == 2'b00) || (mode == 2'b11));
        motor_d  = (state_d == ON) && ((mode == 2'b01) || (mode == 2'b11));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            burst_q  <= '0;
            src_q    <= '0;
            mask_q   <= '0;
            ringer_q <= 1'b0;
            motor_q  <= 1'b0;
            active_q <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            burst_q  <= burst_d;
            src_q    <= src_d;
            mask_q   <= mask_d;
            ringer_q <= ringer_d;
            motor_q  <= motor_d;
            active_q <= active_d;
            missed_q <= missed_d;
        end
    end

    assign ringer     = ringer_q;
    assign motor      = motor_q;
    assign active     = active_q;
    assign active_src = src_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_alert_cadence_ctrl.sv
// tb_alert_cadence_ctrl: table-driven vectors and cadence sequences for
// alert_cadence_ctrl, checked one cycle after each stimulus via a queue.
module tb_alert_cadence_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [1:0] mode;
    logic       dismiss;
    logic       ringer;
    logic       motor;
    logic       active;
    logic [1:0] active_src;
    logic       missed;

    always #5 clk = ~clk;

    alert_cadence_ctrl #(
        .NUM_SRC    (4),
        .ON_CYC     (8),
        .OFF_CYC    (8),
        .MAX_BURSTS (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .mode       (mode),
        .dismiss    (dismiss),
        .ringer     (ringer),
        .motor      (motor),
        .active     (active),
        .active_src (active_src),
        .missed     (missed)
    );

    typedef struct packed {
        logic       r;
        logic       m;
        logic       a;
        logic       ms;
        logic [1:0] src;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic [3:0] rq;
        logic [1:0] md;
        logic       ds;
        out_t       exp;
        string      nm;
    } vec_t;

    out_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[14];

    function automatic out_t o(input logic r, input logic m, input logic a,
                               input logic ms, input logic [1:0] s);
        return out_t'({r, m, a, ms, s});
    endfunction

    task automatic step(input logic rn, input logic [3:0] rq,
                        input logic [1:0] md, input logic ds,
                        input out_t e, input string nm);
        out_t got;
        out_t want;
        reset_n = rn;
        req     = rq;
        mode    = md;
        dismiss = ds;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got  = {ringer, motor, active, missed, active_src};
        want = sb_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got r=%b m=%b a=%b missed=%b src=%0d, expected r=%b m=%b a=%b missed=%b src=%0d",
                     nm, got.r, got.m, got.a, got.ms, got.src,
                     want.r, want.m, want.a, want.ms, want.src);
        end
    endtask

    // Full cadence with req held: 3 x (8 ON + 8 OFF), then the missed pulse.
    task automatic run_cadence(input logic [3:0] rq, input logic [1:0] md,
                               input logic [1:0] s, input logic r,
                               input logic m, input string nm);
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 8; c++)
                step(1'b1, rq, md, 1'b0, o(r, m, 1'b1, 1'b0, s),
                     $sformatf("%s_b%0d_on%0d", nm, b, c));
            for (int c = 0; c < 8; c++)
                step(1'b1, rq, md, 1'b0, o(1'b0, 1'b0, 1'b1, 1'b0, s),
                     $sformatf("%s_b%0d_off%0d", nm, b, c));
        end
        step(1'b1, rq, md, 1'b0, o(1'b0, 1'b0, 1'b0, 1'b1, s),
             $sformatf("%s_missed", nm));
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        mode    = '0;
        dismiss = 1'b0;

        // Reset with all requests, then mode switch on ON cycle 4.
        for (int i = 0; i < 3; i++)
            tbl[i] = '{1'b0, 4'b1111, 2'b11, 1'b0,
                       o(0, 0, 0, 0, 2'd0), "reset"};
        tbl[3] = '{1'b1, 4'b0000, 2'b01, 1'b0,
                   o(0, 0, 0, 0, 2'd0), "idle"};
        for (int i = 4; i < 7; i++)
            tbl[i] = '{1'b1, 4'b0010, 2'b01, 1'b0,
                       o(0, 1, 1, 0, 2'd1), "vib_on"};
        for (int i = 7; i < 12; i++)
            tbl[i] = '{1'b1, 4'b0010, 2'b11, 1'b0,
                       o(1, 1, 1, 0, 2'd1), "both_on"};
        tbl[12] = '{1'b1, 4'b0010, 2'b11, 1'b0,
                    o(0, 0, 1, 0, 2'd1), "mode_off"};
        tbl[13] = '{1'b1, 4'b0000, 2'b11, 1'b0,
                    o(0, 0, 0, 0, 2'd1), "mode_release"};

        for (int i = 0; i < 14; i++)
            step(tbl[i].rst_n, tbl[i].rq, tbl[i].md, tbl[i].ds, tbl[i].exp,
                 $sformatf("tbl%0d_%s", i, tbl[i].nm));

        // Ring cadence, no restart while held, restart after re-raise.
        run_cadence(4'b0100, 2'b00, 2'd2, 1'b1, 1'b0, "ring");
        step(1, 4'b0100, 2'b00, 0, o(0, 0, 0, 0, 2'd2), "ring_norestart");
        step(1, 4'b0000, 2'b00, 0, o(0, 0, 0, 0, 2'd2), "ring_drop");
        step(1, 4'b0100, 2'b00, 0, o(1, 0, 1, 0, 2'd2), "ring_restart");
        step(1, 4'b0000, 2'b00, 0, o(0, 0, 0, 0, 2'd2), "ring_release");

        // Silent mode keeps the cadence and still reports missed.
        run_cadence(4'b0001, 2'b10, 2'd0, 1'b0, 1'b0, "silent");
        step(1, 4'b0000, 2'b10, 0, o(0, 0, 0, 0, 2'd0), "silent_drop");

        // Preemption during OFF restarts counters for source 0.
        for (int c = 0; c < 8; c++)
            step(1, 4'b0100, 2'b00, 0, o(1, 0, 1, 0, 2'd2), "pre_on");
        for (int c = 0; c < 2; c++)
            step(1, 4'b0100, 2'b00, 0, o(0, 0, 1, 0, 2'd2), "pre_off");
        run_cadence(4'b0101, 2'b00, 2'd0, 1'b1, 1'b0, "preempt");
        step(1, 4'b0101, 2'b00, 0, o(1, 0, 1, 0, 2'd2), "pre_resume2");
        step(1, 4'b0000, 2'b00, 0, o(0, 0, 0, 0, 2'd2), "pre_release");

        // Dismiss on ON cycle 4 of source 3, then dismiss beats preemption.
        for (int c = 0; c < 4; c++)
            step(1, 4'b1000, 2'b11, 0, o(1, 1, 1, 0, 2'd3), "dis_on");
        step(1, 4'b1000, 2'b11, 1, o(0, 0, 0, 0, 2'd3), "dis_idle");
        step(1, 4'b1000, 2'b11, 0, o(0, 0, 0, 0, 2'd3), "dis_masked1");
        step(1, 4'b1000, 2'b11, 0, o(0, 0, 0, 0, 2'd3), "dis_masked2");
        step(1, 4'b0000, 2'b11, 0, o(0, 0, 0, 0, 2'd3), "dis_drop");
        step(1, 4'b1000, 2'b11, 0, o(1, 1, 1, 0, 2'd3), "dis_restart");
        step(1, 4'b1001, 2'b11, 1, o(0, 0, 0, 0, 2'd3), "dis_vs_preempt");
        step(1, 4'b1001, 2'b11, 0, o(1, 1, 1, 0, 2'd0), "dis_then_src0");
        step(1, 4'b0000, 2'b11, 0, o(0, 0, 0, 0, 2'd0), "dis_release");

        // Release of the active source beats a simultaneous preemption.
        step(1, 4'b0100, 2'b00, 0, o(1, 0, 1, 0, 2'd2), "rel_on");
        step(1, 4'b0001, 2'b00, 0, o(0, 0, 0, 0, 2'd2), "rel_vs_preempt");
        step(1, 4'b0001, 2'b00, 0, o(1, 0, 1, 0, 2'd0), "rel_then_src0");
        step(1, 4'b0000, 2'b00, 0, o(0, 0, 0, 0, 2'd0), "rel_release");

        // Reset mid-alert, and reset clearing a dismissed source's mask.
        step(1, 4'b0010, 2'b00, 0, o(1, 0, 1, 0, 2'd1), "rst_on1");
        step(1, 4'b0010, 2'b00, 0, o(1, 0, 1, 0, 2'd1), "rst_on2");
        step(0, 4'b0010, 2'b00, 0, o(0, 0, 0, 0, 2'd0), "rst_mid");
        step(1, 4'b0010, 2'b00, 0, o(1, 0, 1, 0, 2'd1), "rst_resume");
        step(1, 4'b0010, 2'b00, 1, o(0, 0, 0, 0, 2'd1), "rst_dismiss");
        step(0, 4'b0010, 2'b00, 0, o(0, 0, 0, 0, 2'd0), "rst_again");
        step(1, 4'b0010, 2'b00, 0, o(1, 0, 1, 0, 2'd1), "rst_unmask");
        step(1, 4'b0000, 2'b00, 0, o(0, 0, 0, 0, 2'd1), "rst_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
